// File: rtl/std_sacc_if.sv
// Handshake and data bundle for std_sacc: go/clear/in from the parent,
// out/count/ovf/done back from the accumulator.
interface std_sacc_if #(
  parameter int width     = 32,
  parameter int cnt_width = 16
);
  logic                 go;
  logic                 clear;
  logic [width-1:0]     in;
  logic [width-1:0]     out;
  logic [cnt_width-1:0] count;
  logic                 ovf;
  logic                 done;

  modport master (
    output go, clear, in,
    input  out, count, ovf, done
  );

  modport slave (
    input  go, clear, in,
    output out, count, ovf, done
  );
endinterface

// File: rtl/std_sacc.sv
// Signed accumulator with go/done handshake, sticky overflow and sample counter.
// Define STD_SACC_SATURATE_EN to clamp out on overflow instead of wrapping.
module std_sacc #(
  parameter int width     = 32,
  parameter int cnt_width = 16
) (
  input  logic  clk,
  input  logic  reset,
  std_sacc_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef STD_SACC_SATURATE_EN
  localparam logic [width-1:0] SAT_MAX = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] SAT_MIN = {1'b1, {(width-1){1'b0}}};
`endif

  logic [1:0]           state_reg,  state_next;
  logic [width-1:0]     in_q_reg,   in_q_next;
  logic [width-1:0]     out_reg,    out_next;
  logic [cnt_width-1:0] count_reg,  count_next;
  logic                 ovf_reg,    ovf_next;

  logic [width:0]       sum;
  logic                 sum_ovf;
  logic [width-1:0]     result;

  // One extra bit of headroom makes overflow a simple top-two-bit mismatch.
  assign sum     = {out_reg[width-1], out_reg} + {in_q_reg[width-1], in_q_reg};
  assign sum_ovf = sum[width] ^ sum[width-1];

`ifdef STD_SACC_SATURATE_EN
  always_comb begin
    result = sum[width-1:0];
    if (sum_ovf) begin
      result = sum[width] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign result = sum[width-1:0];
`endif

  always_comb begin
    state_next = state_reg;
    in_q_next  = in_q_reg;
    out_next   = out_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;

    if (bus.clear) begin
      // Clear wins over go and aborts whatever is in flight, so no done follows.
      state_next = IDLE;
      out_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.go) begin
            in_q_next  = bus.in;
            state_next = ADD;
          end
        end
        ADD: begin
          out_next   = result;
          ovf_next   = ovf_reg | sum_ovf;
          count_next = (&count_reg) ? count_reg : count_reg + 1'b1;
          state_next = DONE;
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      in_q_reg  <= '0;
      out_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      in_q_reg  <= in_q_next;
      out_reg   <= out_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.out   = out_reg;
  assign bus.count = count_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.done  = (state_reg == DONE);

endmodule

// File: tb/tb_std_sacc.sv
// Randomized scoreboard bench for std_sacc (width=8, cnt_width=2).
module tb_std_sacc;
  localparam int W   = 8;
  localparam int CW  = 2;
  localparam int LIM = 1 << (W - 1);
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    int out;
    int cnt;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  std_sacc_if #(.width(W), .cnt_width(CW)) bus ();

  std_sacc #(.width(W), .cnt_width(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model state: plain integer arithmetic on the accumulated value.
  int m_out = 0;
  int m_cnt = 0;
  int m_ovf = 0;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_acc(int v);
    int s;
    s = m_out + v;
    if (s > LIM - 1 || s < -LIM) begin
      m_ovf = 1;
`ifdef STD_SACC_SATURATE_EN
      s = (s > 0) ? LIM - 1 : -LIM;
`else
      s = (s > 0) ? s - 2 * LIM : s + 2 * LIM;
`endif
    end
    m_out = s;
    if (m_cnt < CMAX) m_cnt = m_cnt + 1;
  endfunction

  function automatic void model_clear();
    m_out = 0;
    m_cnt = 0;
    m_ovf = 0;
  endfunction

  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out", $signed(bus.out), mon_e.out);
        check("count", int'(bus.count), mon_e.cnt);
        check("ovf", int'(bus.ovf), mon_e.ovf);
        $display("done: out=%0d count=%0d ovf=%0d", $signed(bus.out), bus.count, bus.ovf);
      end
    end
  end

  task automatic acc(int v);
    int lat;
    exp_t e;
    @(negedge clk);
    bus.go = 1'b1;
    bus.in = W'(v);
    model_acc(v);
    e.out = m_out;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 10);
    check("done_latency", lat, 2);
    @(posedge clk);
    #1 bus.go = 1'b0;
  endtask

  task automatic clr(logic with_go);
    @(negedge clk);
    bus.clear = 1'b1;
    bus.go    = with_go;
    bus.in    = W'($urandom_range(255));
    @(negedge clk);
    bus.clear = 1'b0;
    bus.go    = 1'b0;
    model_clear();
    check("clr_out", $signed(bus.out), m_out);
    check("clr_count", int'(bus.count), m_cnt);
    check("clr_ovf", int'(bus.ovf), m_ovf);
    repeat (3) begin
      @(negedge clk);
      check("clr_no_done", int'(bus.done), 0);
    end
  endtask

  function automatic int rand_val();
    if ($urandom_range(1) == 0) return int'($urandom_range(20)) - 10;
    return int'($urandom_range(255)) - 128;
  endfunction

  initial begin
    bus.go = 1'b0;
    bus.clear = 1'b0;
    bus.in = '0;
    #12;
    check("rst_out", $signed(bus.out), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic accumulate
    acc(10); acc(-3); acc(20);
    // Positive overflow, sticky through a following add
    clr(1'b0);
    acc(100); acc(50); acc(-1);
    // Negative overflow
    clr(1'b1);
    acc(-100); acc(-50);

    // Clear while ADD is in flight
    clr(1'b0);
    @(negedge clk);
    bus.go = 1'b1;
    bus.in = W'(5);
    @(posedge clk);
    #1 bus.clear = 1'b1;
    bus.go = 1'b0;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    check("abort_out", $signed(bus.out), 0);
    check("abort_count", int'(bus.count), 0);
    check("abort_ovf", int'(bus.ovf), 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", int'(bus.done), 0);
    end
    model_clear();
    acc(4);

    // Count saturation
    clr(1'b0);
    repeat (5) acc(1);

    // Async reset mid-ADD
    @(negedge clk);
    bus.go = 1'b1;
    bus.in = W'(37);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_out", $signed(bus.out), 0);
    check("arst_count", int'(bus.count), 0);
    check("arst_ovf", int'(bus.ovf), 0);
    check("arst_done", int'(bus.done), 0);
    bus.go = 1'b0;
    model_clear();
    @(negedge clk);
    check("arst_hold_done", int'(bus.done), 0);
    reset = 1'b1;
    acc(1);

    // Randomized mix of accumulates and clears
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) == 0) clr(1'($urandom_range(1)));
      else acc(rand_val());
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
